// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled so the
// cache (slave modport) and its fetcher/memory-controller environment (master modport) share one definition.
//
// Handshakes: icache_query_en is held by the fetcher until icache_data_en pulses;
// mem_query_en is held by the cache until mem_data_en pulses for one cycle.
// There is no separate ready signal; the one-cycle response pulse completes each transfer.
interface icache_if;
  logic        icache_query_en;
  logic [31:0] icache_query_pc;
  logic        icache_data_en;
  logic [31:0] icache_addr_comfirm;
  logic [31:0] icache_data;
  logic        flush;
  logic        mem_query_en;
  logic [31:0] mem_query_addr;
  logic        mem_data_en;
  logic [31:0] mem_data;

  modport master (
    output icache_query_en, icache_query_pc, flush, mem_data_en, mem_data,
    input  icache_data_en, icache_addr_comfirm, icache_data, mem_query_en, mem_query_addr
  );

  modport slave (
    input  icache_query_en, icache_query_pc, flush, mem_data_en, mem_data,
    output icache_data_en, icache_addr_comfirm, icache_data, mem_query_en, mem_query_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with 4-word lines, refilled one word at a time
// from a single-outstanding-request memory controller.
module icache #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  icache_if.slave    bus,
  output logic [1:0] dbg_state
);
  localparam int LINE_WORDS = 4;
  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int TAG_W      = 28 - INDEX_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DRAIN, S_RESPOND} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       hold_q, hold_d;
  logic [31:0] pc_q, pc_d;
  logic [LINES-1:0] valid_q;

  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES][LINE_WORDS];

  logic [INDEX_WIDTH-1:0] q_idx, l_idx;
  logic [TAG_W-1:0]       q_tag, l_tag;
  logic [1:0]             l_off;
  logic hit, miss_start, fill_we, fill_done;

  assign q_idx = bus.icache_query_pc[3+INDEX_WIDTH:4];
  assign q_tag = bus.icache_query_pc[31:4+INDEX_WIDTH];
  assign l_idx = pc_q[3+INDEX_WIDTH:4];
  assign l_tag = pc_q[31:4+INDEX_WIDTH];
  assign l_off = pc_q[3:2];
  assign hit   = valid_q[q_idx] && (tag_arr[q_idx] == q_tag);

  // A miss invalidates the victim line up front so an aborted refill never leaves stale data hittable.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      req_q   <= 1'b0;
      hold_q  <= 1'b0;
      pc_q    <= 32'd0;
      valid_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
      if (miss_start) valid_q[q_idx] <= 1'b0;
      if (fill_done)  valid_q[l_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      data_arr[l_idx][cnt_q] <= bus.mem_data;
      if (fill_done) tag_arr[l_idx] <= l_tag;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    hold_d     = hold_q;
    pc_d       = pc_q;
    miss_start = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // hold_q blocks the one cycle the fetcher needs to drop a served query.
        hold_d = 1'b0;
        if (bus.icache_query_en && !bus.flush && !hold_q) begin
          pc_d = bus.icache_query_pc;
          if (hit) begin
            state_d = S_RESPOND;
          end else begin
            state_d    = S_REFILL;
            cnt_d      = 2'd0;
            req_d      = 1'b1;
            miss_start = 1'b1;
          end
        end
      end
      S_REFILL: begin
        if (bus.flush) begin
          if (req_q && !bus.mem_data_en) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end else if (req_q && bus.mem_data_en) begin
          fill_we = 1'b1;
          req_d   = 1'b0;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = S_RESPOND;
          end
        end else if (!req_q) begin
          req_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.mem_data_en) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
        hold_d  = !bus.flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.icache_data_en      = (state_q == S_RESPOND) && !bus.flush;
    bus.icache_addr_comfirm = pc_q;
    bus.icache_data         = (state_q == S_RESPOND) ? data_arr[l_idx][l_off] : 32'd0;
    bus.mem_query_en        = req_q;
    bus.mem_query_addr      = {pc_q[31:4], cnt_q, 2'b00};
    dbg_state               = state_q;
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a scripted memory controller serves refills word by word,
// and each scenario task checks the fetch and memory outputs against hand-computed values.
module tb_icache;
  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rdy_in;
  logic [1:0] dbg_state;
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] got_addr [4];
  logic        got_gap  [4];

  icache_if bus();

  icache #(.INDEX_WIDTH(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  task automatic start_query(input logic [31:0] pc);
    @(posedge clk_in); #1;
    bus.icache_query_en = 1'b1;
    bus.icache_query_pc = pc;
  endtask

  task automatic drop_query();
    @(posedge clk_in); #1;
    bus.icache_query_en = 1'b0;
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (bus.mem_query_en) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_mem(input logic [31:0] d);
    @(posedge clk_in); #1;
    bus.mem_data_en = 1'b1;
    bus.mem_data    = d;
    @(posedge clk_in); #1;
    bus.mem_data_en = 1'b0;
  endtask

  // Records the address of each of the four requests and whether the request dropped after each answer.
  task automatic serve_line(input logic [31:0] base);
    bit ok;
    for (int i = 0; i < 4; i++) begin
      got_addr[i] = 32'hFFFF_FFFF;
      got_gap[i]  = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      wait_mem_req(ok);
      if (!ok) return;
      got_addr[i] = bus.mem_query_addr;
      pulse_mem(mem_word(base + 32'(4 * i)));
      if (i < 3) begin
        @(negedge clk_in);
        got_gap[i] = bus.mem_query_en;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL rst_data_en: got %b want 0", bus.icache_data_en); else n_pass++;
    n_total++; if (bus.mem_query_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", bus.mem_query_en); else n_pass++;
    n_total++; if (bus.icache_addr_comfirm !== 32'd0) $display("FAIL rst_confirm: got %h want 0", bus.icache_addr_comfirm); else n_pass++;
    n_total++; if (bus.icache_data !== 32'd0) $display("FAIL rst_data: got %h want 0", bus.icache_data); else n_pass++;
    n_total++; if (bus.mem_query_addr !== 32'd0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_query_addr); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else n_pass++;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic [31:0] exp_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    start_query(32'h100);
    serve_line(32'h100);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (got_addr[i] !== exp_addr[i]) $display("FAIL cold_addr%0d: got %h want %h", i, got_addr[i], exp_addr[i]); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_total++; if (got_gap[i] !== 1'b0) $display("FAIL cold_gap%0d: got %b want 0", i, got_gap[i]); else n_pass++;
    end
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b1) $display("FAIL cold_data_en: got %b want 1", bus.icache_data_en); else n_pass++;
    n_total++; if (bus.icache_data !== 32'h11) $display("FAIL cold_data: got %h want 11", bus.icache_data); else n_pass++;
    n_total++; if (bus.icache_addr_comfirm !== 32'h100) $display("FAIL cold_confirm: got %h want 100", bus.icache_addr_comfirm); else n_pass++;
    drop_query();
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL cold_pulse_end: got %b want 0", bus.icache_data_en); else n_pass++;
  endtask

  task automatic test_hit();
    start_query(32'h108);
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL hit_early: got %b want 0", bus.icache_data_en); else n_pass++;
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b1) $display("FAIL hit_data_en: got %b want 1", bus.icache_data_en); else n_pass++;
    n_total++; if (bus.icache_data !== 32'h33) $display("FAIL hit_data: got %h want 33", bus.icache_data); else n_pass++;
    n_total++; if (bus.icache_addr_comfirm !== 32'h108) $display("FAIL hit_confirm: got %h want 108", bus.icache_addr_comfirm); else n_pass++;
    n_total++; if (bus.mem_query_en !== 1'b0) $display("FAIL hit_no_mem: got %b want 0", bus.mem_query_en); else n_pass++;
    drop_query();
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL hit_pulse_end: got %b want 0", bus.icache_data_en); else n_pass++;
  endtask

  task automatic test_held_query();
    int pulses = 0;
    start_query(32'h10C);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      if (bus.icache_data_en) pulses++;
      if (k == 1) begin
        n_total++; if (bus.icache_data !== 32'h44) $display("FAIL held_data: got %h want 44", bus.icache_data); else n_pass++;
      end
      if (k == 3) begin
        n_total++; if (dbg_state !== 2'd0) $display("FAIL held_state: got %0d want 0", dbg_state); else n_pass++;
        bus.icache_query_en = 1'b0;
      end
    end
    n_total++; if (pulses !== 1) $display("FAIL held_pulses: got %0d want 1", pulses); else n_pass++;
  endtask

  task automatic test_conflict();
    start_query(32'h200);
    serve_line(32'h200);
    n_total++; if (got_addr[0] !== 32'h200) $display("FAIL conf_addr0: got %h want 200", got_addr[0]); else n_pass++;
    n_total++; if (got_addr[3] !== 32'h20C) $display("FAIL conf_addr3: got %h want 20c", got_addr[3]); else n_pass++;
    @(negedge clk_in);
    n_total++; if (bus.icache_data !== 32'hDEAD_0200) $display("FAIL conf_data: got %h want dead0200", bus.icache_data); else n_pass++;
    n_total++; if (bus.icache_addr_comfirm !== 32'h200) $display("FAIL conf_confirm: got %h want 200", bus.icache_addr_comfirm); else n_pass++;
    drop_query();
    start_query(32'h100);
    serve_line(32'h100);
    n_total++; if (got_addr[0] !== 32'h100) $display("FAIL conf_remiss: got %h want 100", got_addr[0]); else n_pass++;
    @(negedge clk_in);
    n_total++; if (bus.icache_data !== 32'h11) $display("FAIL conf_redata: got %h want 11", bus.icache_data); else n_pass++;
    drop_query();
  endtask

  task automatic test_flush_refill();
    bit ok;
    int pulses = 0;
    logic [31:0] exp_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    start_query(32'h200);
    for (int i = 0; i < 2; i++) begin
      wait_mem_req(ok);
      pulse_mem(mem_word(32'h200 + 32'(4 * i)));
    end
    wait_mem_req(ok);
    n_total++; if (ok !== 1'b1 || bus.mem_query_addr !== 32'h208) $display("FAIL flush_w2_addr: got %h want 208", bus.mem_query_addr); else n_pass++;
    @(posedge clk_in); #1;
    bus.flush = 1'b1;
    bus.icache_query_en = 1'b0;
    @(posedge clk_in); #1;
    bus.flush = 1'b0;
    @(negedge clk_in);
    n_total++; if (dbg_state !== 2'd2) $display("FAIL flush_drain_state: got %0d want 2", dbg_state); else n_pass++;
    n_total++; if (bus.mem_query_en !== 1'b1) $display("FAIL flush_drain_req: got %b want 1", bus.mem_query_en); else n_pass++;
    n_total++; if (bus.mem_query_addr !== 32'h208) $display("FAIL flush_drain_addr: got %h want 208", bus.mem_query_addr); else n_pass++;
    pulse_mem(mem_word(32'h208));
    @(negedge clk_in);
    n_total++; if (dbg_state !== 2'd0) $display("FAIL flush_idle_state: got %0d want 0", dbg_state); else n_pass++;
    n_total++; if (bus.mem_query_en !== 1'b0) $display("FAIL flush_idle_req: got %b want 0", bus.mem_query_en); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      if (bus.icache_data_en) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL flush_no_data: got %0d want 0", pulses); else n_pass++;
    start_query(32'h100);
    serve_line(32'h100);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (got_addr[i] !== exp_addr[i]) $display("FAIL flush_refill%0d: got %h want %h", i, got_addr[i], exp_addr[i]); else n_pass++;
    end
    @(negedge clk_in);
    n_total++; if (bus.icache_data !== 32'h11) $display("FAIL flush_redata: got %h want 11", bus.icache_data); else n_pass++;
    drop_query();
  endtask

  task automatic test_rdy_freeze();
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    bus.icache_query_en = 1'b1;
    bus.icache_query_pc = 32'h108;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL rdy_blocked%0d: got %b want 0", k, bus.icache_data_en); else n_pass++;
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b1) $display("FAIL rdy_resume: got %b want 1", bus.icache_data_en); else n_pass++;
    n_total++; if (bus.icache_data !== 32'h33) $display("FAIL rdy_data: got %h want 33", bus.icache_data); else n_pass++;
    rdy_in = 1'b0;
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b1) $display("FAIL rdy_frozen_en: got %b want 1", bus.icache_data_en); else n_pass++;
    n_total++; if (dbg_state !== 2'd3) $display("FAIL rdy_frozen_state: got %0d want 3", dbg_state); else n_pass++;
    bus.icache_query_en = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL rdy_release: got %b want 0", bus.icache_data_en); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_query(32'h104);
    repeat (2) @(negedge clk_in);
    n_total++; if (bus.icache_data_en !== 1'b1) $display("FAIL rmid_pre_en: got %b want 1", bus.icache_data_en); else n_pass++;
    #1 rst_in = 1'b1;
    #1;
    n_total++; if (bus.icache_data_en !== 1'b0) $display("FAIL rmid_data_en: got %b want 0", bus.icache_data_en); else n_pass++;
    n_total++; if (bus.icache_addr_comfirm !== 32'd0) $display("FAIL rmid_confirm: got %h want 0", bus.icache_addr_comfirm); else n_pass++;
    n_total++; if (bus.icache_data !== 32'd0) $display("FAIL rmid_data: got %h want 0", bus.icache_data); else n_pass++;
    bus.icache_query_en = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    start_query(32'h104);
    wait_mem_req(ok);
    n_total++; if (ok !== 1'b1 || bus.mem_query_addr !== 32'h100) $display("FAIL rmid_miss: got %h want 100", bus.mem_query_addr); else n_pass++;
    #1 rst_in = 1'b1;
    bus.icache_query_en = 1'b0;
    #1 rst_in = 1'b0;
    pulse_mem(32'h11);
    @(negedge clk_in);
    n_total++; if (dbg_state !== 2'd0) $display("FAIL rmid_ignore_state: got %0d want 0", dbg_state); else n_pass++;
    n_total++; if (bus.mem_query_en !== 1'b0) $display("FAIL rmid_ignore_req: got %b want 0", bus.mem_query_en); else n_pass++;
    start_query(32'h104);
    serve_line(32'h100);
    n_total++; if (got_addr[0] !== 32'h100) $display("FAIL rmid_refill: got %h want 100", got_addr[0]); else n_pass++;
    @(negedge clk_in);
    n_total++; if (bus.icache_data !== 32'h22) $display("FAIL rmid_data2: got %h want 22", bus.icache_data); else n_pass++;
    n_total++; if (bus.icache_addr_comfirm !== 32'h104) $display("FAIL rmid_confirm2: got %h want 104", bus.icache_addr_comfirm); else n_pass++;
    drop_query();
  endtask

  initial begin
    bus.icache_query_en = 1'b0;
    bus.icache_query_pc = 32'd0;
    bus.flush           = 1'b0;
    bus.mem_data_en     = 1'b0;
    bus.mem_data        = 32'd0;
    rdy_in              = 1'b1;
    test_reset();
    test_cold_miss();
    test_hit();
    test_held_query();
    test_conflict();
    test_flush_refill();
    test_rdy_freeze();
    test_reset_mid();
    repeat (2) @(posedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
